// File: rtl/qracc_window_buffer.sv
// qracc_window_buffer
// Ping-pong convolution-window register that sits between the activation
// buffer read port and the QRAcc MAC array. The controller streams row
// segments into the fill bank and then commits it. The MAC array drains the
// committed bank through win_valid_o/win_ready_i while the other bank fills.
//
// Ports
//   clk, nrst        clock, async active-low reset
//   clear_i          sync clear, returns to the reset state
//   wr_en_i          write a segment of wr_nelems_i elements at wr_addr_i
//   wr_addr_i        element offset of the segment in the window
//   wr_data_i        segment data, element k at [k*elementWidth +: elementWidth]
//   wr_nelems_i      valid elements in wr_data_i (clamped to wordElems)
//   commit_i         hand the fill bank over to the MAC side
//   win_full_o       fill bank still occupied; writes/commits are dropped
//   win_valid_o      output bank holds a committed window
//   win_ready_i      MAC array takes the window
//   win_data_o       output bank contents, element i at [i*elementWidth +: elementWidth]
//   overflow_o       sticky: dropped write/commit, or element past numRows
//
// Build option
//   QRACC_WB_ZERO_ON_RELEASE_EN : zero a bank on the handshake edge that
//   releases it, so unwritten positions read 0 in later windows.

// One window element, both banks.
module qracc_wb_cell #(
    parameter int elementWidth = 8,
    parameter int wordElems    = 16,
    parameter int addrWidth    = 7,
    parameter int idx          = 0
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     clear_i,
    input  logic                                     wr_acc,
    input  logic                                     fill_sel,
    input  logic                                     release_en,
    input  logic                                     out_sel,
    input  logic [addrWidth-1:0]                     wr_addr,
    input  logic [$clog2(wordElems+1)-1:0]           n_eff,
    input  logic [wordElems-1:0][elementWidth-1:0]   wdata,
    output logic [1:0][elementWidth-1:0]             q
);
    localparam int IW = addrWidth + 1;
    localparam int KW = $clog2(wordElems);

    logic [IW-1:0] my_idx;
    logic [IW-1:0] base;
    logic [IW-1:0] off;
    logic          hit;

    // Offset of this element inside the incoming segment; the segment
    // covers it when idx >= addr and idx - addr < n_eff.
    assign my_idx = IW'(idx);
    assign base   = {1'b0, wr_addr};
    assign off    = my_idx - base;
    assign hit    = (my_idx >= base) && (off < IW'(n_eff));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q <= '0;
        end else if (clear_i) begin
            q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                // A released bank is never the fill target of an accepted
                // write in the same cycle, so the two branches cannot collide.
                if (release_en && (out_sel == 1'(b)))
                    q[b] <= '0;
                else if (wr_acc && hit && (fill_sel == 1'(b)))
                    q[b] <= wdata[off[KW-1:0]];
            end
        end
    end
endmodule

module qracc_window_buffer #(
    parameter int elementWidth = 8,
    parameter int numRows      = 128,
    parameter int wordElems    = 16,
    parameter int addrWidth    = $clog2(numRows)
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                clear_i,
    input  logic                                wr_en_i,
    input  logic [addrWidth-1:0]                wr_addr_i,
    input  logic [wordElems*elementWidth-1:0]   wr_data_i,
    input  logic [$clog2(wordElems+1)-1:0]      wr_nelems_i,
    input  logic                                commit_i,
    output logic                                win_full_o,
    output logic                                win_valid_o,
    input  logic                                win_ready_i,
    output logic [numRows*elementWidth-1:0]     win_data_o,
    output logic                                overflow_o
);
    localparam int NW = $clog2(wordElems + 1);
    localparam int EW = addrWidth + 2;

    logic [1:0] bank_full;
    logic       fill_sel;
    logic       out_sel;
    logic       wr_acc;
    logic       cm_acc;
    logic       hs;
    logic       drop;
    logic       past_end;
    logic       release_en;
    logic [NW-1:0] n_eff;
    logic [EW-1:0] wr_end;
    logic [wordElems-1:0][elementWidth-1:0] wdata;
    logic [numRows-1:0][1:0][elementWidth-1:0] cell_q;

    assign win_full_o  = bank_full[fill_sel];
    assign win_valid_o = bank_full[out_sel];

    assign wr_acc = wr_en_i  && !win_full_o;
    assign cm_acc = commit_i && !win_full_o;
    assign hs     = win_valid_o && win_ready_i;
    assign drop   = (wr_en_i || commit_i) && win_full_o;

    assign n_eff  = (wr_nelems_i > NW'(wordElems)) ? NW'(wordElems) : wr_nelems_i;
    // One past the last element written; anything beyond numRows is lost.
    assign wr_end   = EW'(wr_addr_i) + EW'(n_eff);
    assign past_end = wr_acc && (wr_end > EW'(numRows));

    assign wdata = wr_data_i;

`ifdef QRACC_WB_ZERO_ON_RELEASE_EN
    assign release_en = hs;
`else
    assign release_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank_full  <= '0;
            fill_sel   <= 1'b0;
            out_sel    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            bank_full  <= '0;
            fill_sel   <= 1'b0;
            out_sel    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            // hs needs bank[out_sel] full and cm_acc needs bank[fill_sel]
            // empty, so these always touch different bits.
            if (hs) begin
                bank_full[out_sel] <= 1'b0;
                out_sel            <= ~out_sel;
            end
            if (cm_acc) begin
                bank_full[fill_sel] <= 1'b1;
                fill_sel            <= ~fill_sel;
            end
            if (drop || past_end)
                overflow_o <= 1'b1;
        end
    end

    for (genvar i = 0; i < numRows; i++) begin : g_elem
        qracc_wb_cell #(
            .elementWidth (elementWidth),
            .wordElems    (wordElems),
            .addrWidth    (addrWidth),
            .idx          (i)
        ) u_cell (
            .clk        (clk),
            .nrst       (nrst),
            .clear_i    (clear_i),
            .wr_acc     (wr_acc),
            .fill_sel   (fill_sel),
            .release_en (release_en),
            .out_sel    (out_sel),
            .wr_addr    (wr_addr_i),
            .n_eff      (n_eff),
            .wdata      (wdata),
            .q          (cell_q[i])
        );
        assign win_data_o[i*elementWidth +: elementWidth] = cell_q[i][out_sel];
    end
endmodule

// File: tb/tb_qracc_window_buffer.sv
module tb_qracc_window_buffer;
    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           clear_i = 1'b0;
    logic           wr_en_i = 1'b0;
    logic [6:0]     wr_addr_i = '0;
    logic [127:0]   wr_data_i = '0;
    logic [4:0]     wr_nelems_i = '0;
    logic           commit_i = 1'b0;
    logic           win_full_o;
    logic           win_valid_o;
    logic           win_ready_i = 1'b0;
    logic [1023:0]  win_data_o;
    logic           overflow_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1023:0] sb[$];

    qracc_window_buffer dut (
        .clk         (clk),
        .nrst        (nrst),
        .clear_i     (clear_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_nelems_i (wr_nelems_i),
        .commit_i    (commit_i),
        .win_full_o  (win_full_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_data_o  (win_data_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted window is checked against the oldest expectation.
    always @(negedge clk) begin
        if (nrst && !clear_i && win_valid_o && win_ready_i) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL window_unexpected: got %h, required none queued", win_data_o);
            end else begin
                logic [1023:0] e;
                e = sb.pop_front();
                if (win_data_o !== e) begin
                    n_bad++;
                    $display("FAIL window_data: got %h required %h", win_data_o, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock with the currently driven inputs, then return them to idle.
    task automatic step();
        @(posedge clk);
        #1;
        wr_en_i = 1'b0; commit_i = 1'b0; win_ready_i = 1'b0; clear_i = 1'b0;
        wr_nelems_i = '0; wr_data_i = '0; wr_addr_i = '0;
    endtask

    task automatic wr(input int addr, input int n, input logic [15:0][7:0] d, input bit cm);
        wr_en_i = 1'b1; wr_addr_i = 7'(addr); wr_nelems_i = 5'(n);
        wr_data_i = d; commit_i = cm;
        step();
    endtask

    task automatic commit();
        commit_i = 1'b1;
        step();
    endtask

    task automatic take();
        win_ready_i = 1'b1;
        step();
    endtask

    initial begin
        logic [15:0][7:0]  d;
        logic [127:0][7:0] w;

        // Reset
        #12 nrst = 1'b1;
        #1;
        chk("rst_valid", 32'(win_valid_o), 0);
        chk("rst_full", 32'(win_full_o), 0);
        chk("rst_overflow", 32'(overflow_o), 0);
        chk("rst_data_zero", 32'(win_data_o == '0), 1);
        step();

        // Single window: 1..16 at 0 and at 16
        for (int k = 0; k < 16; k++) d[k] = 8'(k + 1);
        wr(0, 16, d, 1'b0);
        wr(16, 16, d, 1'b0);
        w = '0;
        for (int k = 0; k < 32; k++) w[k] = 8'((k % 16) + 1);
        sb.push_back(w);
        commit();
        chk("single_valid", 32'(win_valid_o), 1);
        chk("single_full", 32'(win_full_o), 0);
        chk("single_overflow", 32'(overflow_o), 0);
        take();
        chk("single_drained", 32'(win_valid_o), 0);

        // Boundary: 16 elements at 120, only 120..127 land
        for (int k = 0; k < 16; k++) d[k] = 8'(8'h80 + k);
        wr(120, 16, d, 1'b0);
        chk("bound_overflow", 32'(overflow_o), 1);
        w = '0;
        for (int k = 0; k < 8; k++) w[120 + k] = 8'(8'h80 + k);
        sb.push_back(w);
        commit();
        take();
        clear_i = 1'b1;
        step();
        chk("clear1_overflow", 32'(overflow_o), 0);
        chk("clear1_valid", 32'(win_valid_o), 0);

        // Ping-pong: fill both banks with ready low
        d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        wr(0, 4, d, 1'b0);
        w = '0; w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        sb.push_back(w);
        commit();
        d = '0; d[0] = 8'hB0; d[1] = 8'hB1;
        wr(8, 2, d, 1'b0);
        w = '0; w[8] = 8'hB0; w[9] = 8'hB1;
        sb.push_back(w);
        commit();
        chk("pp_full", 32'(win_full_o), 1);
        chk("pp_valid", 32'(win_valid_o), 1);
        chk("pp_overflow_clean", 32'(overflow_o), 0);
        // Third window (write + commit) is dropped
        d = '0; d[0] = 8'hEE;
        wr(0, 1, d, 1'b1);
        chk("pp_drop_overflow", 32'(overflow_o), 1);
        chk("pp_drop_full", 32'(win_full_o), 1);
        // Commit and handshake together: handshake only
        commit_i = 1'b1; win_ready_i = 1'b1;
        step();
        chk("simul_full", 32'(win_full_o), 0);
        chk("simul_valid", 32'(win_valid_o), 1);
        take();
        chk("pp_empty_valid", 32'(win_valid_o), 0);

        // Write+commit same cycle, zero-length write, release behaviour
        clear_i = 1'b1;
        step();
        d = '1;
        wr(3, 0, d, 1'b0);
        chk("n0_overflow", 32'(overflow_o), 0);
        d = '0; d[0] = 8'hAA;
        w = '0; w[0] = 8'hAA;
        sb.push_back(w);
        wr(0, 1, d, 1'b1);
        chk("wc_valid", 32'(win_valid_o), 1);
        take();
        d = '0; d[0] = 8'h07;
        w = '0; w[5] = 8'h07;
        sb.push_back(w);
        wr(5, 1, d, 1'b1);
        take();
        w = '0;
`ifndef QRACC_WB_ZERO_ON_RELEASE_EN
        w[0] = 8'hAA;
`endif
        sb.push_back(w);
        commit();
        take();
        w = '0;
`ifndef QRACC_WB_ZERO_ON_RELEASE_EN
        w[5] = 8'h07;
`endif
        sb.push_back(w);
        commit();
        take();

        // Pending window plus overflow, then clear (this window is discarded)
        commit();
        d = '0;
        wr(127, 2, d, 1'b0);
        chk("preclear_valid", 32'(win_valid_o), 1);
        chk("preclear_overflow", 32'(overflow_o), 1);
        clear_i = 1'b1;
        step();
        chk("clear_valid", 32'(win_valid_o), 0);
        chk("clear_full", 32'(win_full_o), 0);
        chk("clear_overflow", 32'(overflow_o), 0);
        chk("clear_data_zero", 32'(win_data_o == '0), 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
